// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the rectangle filler and the display scaler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: geometry/width constants, fill FSM state enum, fill command struct.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int ADDR_W    = 17;
  localparam int COLOR_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fb_state_t;

  typedef struct packed {
    logic [8:0]         x;
    logic [7:0]         y;
    logic [8:0]         w;
    logic [7:0]         h;
    logic [COLOR_W-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Rectangle address walker: row_base/col/row counters and last-pixel detect.
// Latency: addr is combinational from the counters; counters step on the clock after advance.
// Backpressure: counters hold while advance is low, so addr stays stable under a stalled write.
// Ports: clk, reset (async, active-high); load with base/w/h starts a new walk;
//        advance steps one pixel; addr is the current pixel; last flags the final pixel.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  logic [ADDR_W-1:0] row_base;
  logic [8:0]        col;
  logic [7:0]        row;
  logic [8:0]        w_q;
  logic [7:0]        h_q;
  logic              col_last;
  logic              row_last;

  assign col_last = (col == w_q - 9'd1);
  assign row_last = (row == h_q - 8'd1);
  assign last     = col_last && row_last;
  assign addr     = row_base + {{(ADDR_W-9){1'b0}}, col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base <= '0;
      col      <= '0;
      row      <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else if (load) begin
      row_base <= base;
      col      <= '0;
      row      <= '0;
      w_q      <= w;
      h_q      <= h;
    end else if (advance && !last) begin
      // The final pixel does not step, so addr never runs past the rectangle
      // (and therefore never past the end of the frame buffer).
      if (col_last) begin
        col      <= '0;
        row      <= row + 8'd1;
        row_base <= row_base + ROW_STEP;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_filler.sv
// Solid-colour rectangle filler for the 320x240 12-bit frame buffer write port.
// Latency: command accepted at cycle 0, SETUP at 1, first write at 2, done at 2+w*h.
// Backpressure: cmd_ready only in IDLE; fb_write_ready low freezes addr/data/en.
// Ports: clk, reset (async, active-high); cmd_* valid/ready fill command;
//        fb_write_* pixel write port; busy/done/err status.
// Build option: define RECT_FILL_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_filler
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x,
  input  logic [7:0]         cmd_y,
  input  logic [8:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [ADDR_W-1:0]  fb_write_addr,
  output logic [COLOR_W-1:0] fb_write_data,
  output logic               fb_write_en,
  input  logic               fb_write_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  fb_state_t         state, state_nxt;
  rect_cmd_t         cmd_q;
  logic              err_q;
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] row_base;
  logic [8:0]        w_eff;
  logic [7:0]        h_eff;
  logic              empty;
  logic              reject;
  logic              load;
  logic              advance;
  logic              last;

  // y*320 + x without a multiplier: 320 = 256 + 64.
  assign y_ext    = ADDR_W'(cmd_q.y);
  assign row_base = (y_ext << 8) + (y_ext << 6) + ADDR_W'(cmd_q.x);

`ifdef RECT_FILL_CLIP_EN
  logic [8:0] room_x;
  logic [7:0] room_y;
  logic       off_screen;

  always_comb begin
    room_x     = 9'(FB_WIDTH) - cmd_q.x;
    room_y     = 8'(FB_HEIGHT) - cmd_q.y;
    off_screen = (cmd_q.x >= 9'(FB_WIDTH)) || (cmd_q.y >= 8'(FB_HEIGHT));
    w_eff      = (cmd_q.w > room_x) ? room_x : cmd_q.w;
    h_eff      = (cmd_q.h > room_y) ? room_y : cmd_q.h;
    // room_x/room_y wrap when off screen; off_screen masks that case.
    empty      = off_screen || (w_eff == 9'd0) || (h_eff == 8'd0);
    reject     = 1'b0;
  end
`else
  logic [9:0] x_end;
  logic [8:0] y_end;

  always_comb begin
    x_end  = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
    y_end  = {1'b0, cmd_q.y} + {1'b0, cmd_q.h};
    w_eff  = cmd_q.w;
    h_eff  = cmd_q.h;
    // An empty rectangle completes cleanly even if its origin is off screen.
    empty  = (cmd_q.w == 9'd0) || (cmd_q.h == 8'd0);
    reject = !empty && ((x_end > 10'(FB_WIDTH)) || (y_end > 9'(FB_HEIGHT)));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
      end
      if (state == SETUP) begin
        err_q <= reject;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    fb_write_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = (empty || reject) ? DONE : FILL;
      end
      FILL: begin
        fb_write_en = 1'b1;
        if (fb_write_ready && last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load          = (state == SETUP);
  assign advance       = fb_write_en && fb_write_ready;
  assign fb_write_data = cmd_q.color;

  fb_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .base    (row_base),
    .w       (w_eff),
    .h       (h_eff),
    .addr    (fb_write_addr),
    .last    (last)
  );

endmodule

// File: tb/tb_fb_rect_filler.sv
// Self-checking bench for fb_rect_filler: reference model fills a scoreboard
// of expected pixel writes and completions; a negedge monitor compares.
// Build option: RECT_FILL_CLIP_EN selects clipping expectations in the model.
module tb_fb_rect_filler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic [16:0] fb_write_addr;
  logic [11:0] fb_write_data;
  logic        fb_write_en;
  logic        fb_write_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  fb_rect_filler dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_color      (cmd_color),
    .fb_write_addr  (fb_write_addr),
    .fb_write_data  (fb_write_data),
    .fb_write_en    (fb_write_en),
    .fb_write_ready (fb_write_ready),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int err; int n; } dn_t;

  wr_t exp_wr_q[$];
  dn_t exp_dn_q[$];

  int          rdy_mode = 0;
  int          rcnt = 0;
  int          neg_cnt = 0;
  int          t0 = 0;
  int          last_acc = 0;
  int          wr_idx = 0;
  bit          prev_stall = 0;
  bit          rdy_chk = 0;
  logic [16:0] prev_addr = '0;
  logic [11:0] prev_data = '0;

  // Reference model: expected writes in raster order and the completion record.
  task automatic push_expected(input int x, input int y, input int w, input int h, input int color);
    int we = w;
    int he = h;
    int e = 0;
    bit empty = 0;
`ifdef RECT_FILL_CLIP_EN
    if (x >= 320 || y >= 240) empty = 1;
    else begin
      if (we > 320 - x) we = 320 - x;
      if (he > 240 - y) he = 240 - y;
    end
    if (we == 0 || he == 0) empty = 1;
`else
    if (w == 0 || h == 0) empty = 1;
    else if (x + w > 320 || y + h > 240) begin
      empty = 1;
      e = 1;
    end
`endif
    if (!empty) begin
      for (int r = 0; r < he; r++)
        for (int c = 0; c < we; c++)
          exp_wr_q.push_back('{addr: (y + r) * 320 + x + c, data: color});
    end
    exp_dn_q.push_back('{err: e, n: (empty ? 0 : we * he)});
  endtask

  task automatic send(input int x, input int y, input int w, input int h, input int color);
    int k;
    push_expected(x, y, w, h, color);
    @(posedge clk);
    #1;
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 12'(color);
    cmd_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && exp_dn_q.size() != 0; k++) @(negedge clk);
    chk("idle_timeout", exp_dn_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Write-port ready: always high, or a 1,0,0 repeating pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) fb_write_ready = 1'b1;
      else begin
        rcnt++;
        fb_write_ready = (rcnt % 3 == 1);
      end
    end
  end

  always @(negedge clk) begin
    neg_cnt++;
    if (rdy_chk) begin
      chk("ready_after_done", cmd_ready, 1);
      rdy_chk = 0;
    end
    if (prev_stall) begin
      chk("hold_en", fb_write_en, 1);
      chk("hold_addr", fb_write_addr, prev_addr);
      chk("hold_data", fb_write_data, prev_data);
    end
    prev_stall = fb_write_en && !fb_write_ready;
    prev_addr  = fb_write_addr;
    prev_data  = fb_write_data;
    chk("err_only_with_done", err & ~done, 0);
    if (cmd_valid && cmd_ready) begin
      t0 = neg_cnt;
      wr_idx = 0;
    end
    if (fb_write_en) chk("busy_in_fill", busy, 1);
    if (fb_write_en && fb_write_ready) begin
      chk("wr_expected", exp_wr_q.size() > 0, 1);
      if (exp_wr_q.size() > 0) begin
        wr_t e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", fb_write_addr, e.addr);
        chk("wr_data", fb_write_data, e.data);
        if (rdy_mode == 0) chk("wr_cycle", neg_cnt, t0 + 2 + wr_idx);
        wr_idx++;
        last_acc = neg_cnt;
      end
    end
    if (done) begin
      chk("done_expected", exp_dn_q.size() > 0, 1);
      if (exp_dn_q.size() > 0) begin
        dn_t d;
        d = exp_dn_q.pop_front();
        chk("done_err", err, d.err);
        chk("done_writes", wr_idx, d.n);
        if (rdy_mode == 0) chk("done_cycle", neg_cnt, t0 + 2 + d.n);
        else if (d.n > 0) chk("done_after_last", neg_cnt, last_acc + 1);
        chk("ready_low_in_done", cmd_ready, 0);
        chk("en_low_in_done", fb_write_en, 0);
      end
      rdy_chk = 1;
    end
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_en", fb_write_en, 0);
    chk("rst_addr", fb_write_addr, 0);
    chk("rst_data", fb_write_data, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: basic 4x2 fill at origin
    send(0, 0, 4, 2, 12'hF00);
    wait_idle();
    // 2: bottom-right corner row, maximum address
    send(316, 239, 4, 1, 12'h0F0);
    wait_idle();
    // 3: same as 1 under write-port backpressure
    rdy_mode = 1;
    send(0, 0, 4, 2, 12'hF00);
    wait_idle();
    rdy_mode = 0;
    // 4: empty rectangles
    send(10, 10, 0, 5, 12'h00F);
    wait_idle();
    send(10, 10, 5, 0, 12'h00F);
    wait_idle();
    // 5: overhanging rectangle (rejected or clipped), and an off-screen origin
    send(300, 230, 40, 20, 12'hABC);
    wait_idle();
    send(320, 0, 5, 1, 12'h123);
    wait_idle();
    // a few random in-bounds rectangles
    for (int i = 0; i < 4; i++) begin
      send($urandom_range(0, 315), $urandom_range(0, 235), $urandom_range(1, 5),
           $urandom_range(1, 5), $urandom_range(0, 4095));
      wait_idle();
    end
    // 6: reset in the middle of a 10x10 fill
    send(5, 5, 10, 10, 12'h555);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    exp_wr_q.delete();
    exp_dn_q.delete();
    #1;
    chk("midrst_en", fb_write_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("postrst_ready", cmd_ready, 1);
    send(7, 3, 1, 1, 12'h0FF);
    wait_idle();

    chk("leftover_writes", exp_wr_q.size(), 0);
    chk("leftover_done", exp_dn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
